// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared widths, FSM state type and round-robin pick for the mux arbiter
package mux_arb_pkg;
  localparam int NREQ  = 8;
  localparam int SELW  = 3;
  localparam int DATAW = 32;
  typedef enum logic {IDLE, GRANT} state_e;
  // Returns {found, index}; scans ptr+1 .. ptr+8 so ptr itself is checked last.
  function automatic logic [SELW:0] rr_pick(input logic [NREQ-1:0] req, input logic [SELW-1:0] ptr);
    logic [SELW:0] r;
    logic [SELW-1:0] idx;
    r = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = ptr + SELW'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_mux8to1.sv
// mux8to1: 8-input data select, In(i+1) chosen by Sel=i
module mux8to1
  import mux_arb_pkg::*;
(
  input  logic [SELW-1:0]  Sel,
  input  logic [DATAW-1:0] In1,
  input  logic [DATAW-1:0] In2,
  input  logic [DATAW-1:0] In3,
  input  logic [DATAW-1:0] In4,
  input  logic [DATAW-1:0] In5,
  input  logic [DATAW-1:0] In6,
  input  logic [DATAW-1:0] In7,
  input  logic [DATAW-1:0] In8,
  output logic [DATAW-1:0] Out
);
  logic [DATAW-1:0] in_a [NREQ];
  assign in_a = '{In1, In2, In3, In4, In5, In6, In7, In8};
  assign Out = in_a[Sel];
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the shared 8:1 mux with packet hold and valid/ready output
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ-1:0]       Last,
  input  logic [NREQ*DATAW-1:0] Data,
  output logic [NREQ-1:0]       Grant,
  output logic [SELW-1:0]       Sel,
  output logic [DATAW-1:0]      Out,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Busy
);
  localparam logic [3:0] HOLD = 4'(MAX_HOLD);
  state_e state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [SELW:0] pick;
  logic beat, rel;
  assign Busy     = state_q == GRANT;
  assign Sel      = sel_q;
  assign Grant    = Busy ? NREQ'(1) << sel_q : '0;
  assign OutValid = Busy & Req[sel_q];
  assign beat     = OutValid & OutReady;
  assign rel      = Busy & (~Req[sel_q] | (beat & (Last[sel_q] | (cnt_q + 4'd1 == HOLD))));
  // In GRANT the search rotates past the current owner, which becomes the new ptr on release.
  assign pick     = rr_pick(Req, Busy ? sel_q : ptr_q);
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = rel ? sel_q : ptr_q;
    cnt_d   = rel ? 4'd0 : cnt_q + 4'(beat);
    if (!Busy || rel) begin
      state_d = pick[SELW] ? GRANT : IDLE;
      sel_d   = pick[SELW] ? pick[SELW-1:0] : sel_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= SELW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  mux8to1 u_mux (
    .Sel(sel_q),
    .In1(Data[0*DATAW +: DATAW]),
    .In2(Data[1*DATAW +: DATAW]),
    .In3(Data[2*DATAW +: DATAW]),
    .In4(Data[3*DATAW +: DATAW]),
    .In5(Data[4*DATAW +: DATAW]),
    .In6(Data[5*DATAW +: DATAW]),
    .In7(Data[6*DATAW +: DATAW]),
    .In8(Data[7*DATAW +: DATAW]),
    .Out(Out)
  );
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scenario tasks with a beat scoreboard for mux_rr_arbiter
module tb_mux_rr_arbiter;
  logic clk = 0, rst_n = 0, OutReady = 0;
  logic [7:0] Req = '0, Last = '0, Grant;
  logic [255:0] Data;
  logic [2:0] Sel;
  logic [31:0] Out;
  logic OutValid, Busy;
  int checks = 0, failures = 0;
  typedef struct packed {logic [2:0] sel; logic [31:0] data;} exp_t;
  exp_t sb[$];

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .Last(Last), .Data(Data), .Grant(Grant),
    .Sel(Sel), .Out(Out), .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(int i);
    return {8'hA5, 8'(i), 16'h5A00 + 16'(i * 3)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(int s);
    exp_t e;
    e.sel = 3'(s);
    e.data = word(s);
    sb.push_back(e);
  endtask

  task automatic reset_dut;
    rst_n = 0; Req = '0; Last = '0; OutReady = 0;
    sb.delete();
    #2 rst_n = 1;
  endtask

  task automatic test_reset;
    tick;
    checks++;
    if ({Grant, Sel, OutValid, Busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset grant=%h sel=%0d valid=%b busy=%b want all 0", Grant, Sel, OutValid, Busy);
    end
    rst_n = 1;
  endtask

  task automatic test_single;
    exp_t e;
    int nb = 0;
    reset_dut;
    Req = 8'h01; OutReady = 1;
    push(0); push(0);
    tick;
    checks++;
    if (Grant !== 8'h01) begin failures++; $display("FAIL single_latency grant=%h want 01", Grant); end
    for (int c = 0; c < 6; c++) begin
      Req = nb >= 2 ? 8'h00 : 8'h01;
      Last = {7'b0, nb == 1};
      #1;
      if (OutValid && OutReady) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL single_extra_beat sel=%0d want none", Sel); end
        else begin
          e = sb.pop_front();
          if ({Sel, Out} !== {e.sel, e.data}) begin failures++; $display("FAIL single_beat sel=%0d out=%h want sel=%0d out=%h", Sel, Out, e.sel, e.data); end
        end
        nb++;
      end
      tick;
    end
    checks++;
    if (nb != 2 || Grant !== 8'h00 || Busy !== 1'b0) begin failures++; $display("FAIL single_end beats=%0d grant=%h busy=%b want 2 00 0", nb, Grant, Busy); end
  endtask

  task automatic test_all_rotate;
    exp_t e;
    reset_dut;
    Req = 8'hFF; Last = 8'hFF; OutReady = 1;
    for (int i = 0; i < 9; i++) push(i % 8);
    tick;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (OutValid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL rotate_valid cycle=%0d valid=%b want 1", c, OutValid); end
      else begin
        e = sb.pop_front();
        if ({Sel, Out, Grant} !== {e.sel, e.data, 8'(1) << e.sel}) begin failures++; $display("FAIL rotate_owner sel=%0d out=%h grant=%h want sel=%0d out=%h", Sel, Out, Grant, e.sel, e.data); end
      end
      tick;
    end
  endtask

  task automatic test_hold_single;
    exp_t e;
    reset_dut;
    Req = 8'h08; OutReady = 1;
    repeat (8) push(3);
    tick;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (OutValid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL hold3_bubble cycle=%0d valid=%b want 1", c, OutValid); end
      else begin
        e = sb.pop_front();
        if ({Sel, Out} !== {e.sel, e.data}) begin failures++; $display("FAIL hold3_owner sel=%0d out=%h want sel=%0d out=%h", Sel, Out, e.sel, e.data); end
      end
      tick;
    end
  endtask

  task automatic test_max_hold_rotate;
    exp_t e;
    reset_dut;
    Req = 8'h28; OutReady = 1;
    repeat (4) push(3);
    repeat (4) push(5);
    repeat (4) push(3);
    tick;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (OutValid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL maxhold_bubble cycle=%0d valid=%b want 1", c, OutValid); end
      else begin
        e = sb.pop_front();
        if ({Sel, Out} !== {e.sel, e.data}) begin failures++; $display("FAIL maxhold_owner cycle=%0d sel=%0d want %0d", c, Sel, e.sel); end
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    reset_dut;
    Req = 8'h20; OutReady = 1;
    repeat (4) push(5);
    push(2);
    tick;
    e = sb.pop_front();
    checks++;
    if (OutValid !== 1'b1 || {Sel, Out} !== {e.sel, e.data}) begin failures++; $display("FAIL bp_first valid=%b sel=%0d want 1 5", OutValid, Sel); end
    tick;
    OutReady = 0; Req = 8'h24;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (Grant !== 8'h20 || OutValid !== 1'b1 || Out !== word(5)) begin failures++; $display("FAIL bp_stall grant=%h valid=%b out=%h want 20 1 %h", Grant, OutValid, Out, word(5)); end
      tick;
    end
    OutReady = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (OutValid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL bp_resume cycle=%0d valid=%b want 1", c, OutValid); end
      else begin
        e = sb.pop_front();
        if ({Sel, Out} !== {e.sel, e.data}) begin failures++; $display("FAIL bp_owner cycle=%0d sel=%0d want %0d", c, Sel, e.sel); end
      end
      tick;
    end
  endtask

  task automatic test_withdraw;
    exp_t e;
    reset_dut;
    Req = 8'h40; Last = 8'hFF; OutReady = 1;
    tick;
    Req = 8'h81;
    #1;
    checks++;
    if (OutValid !== 1'b0 || Sel !== 3'd6 || Busy !== 1'b1) begin failures++; $display("FAIL withdraw_nobeat valid=%b sel=%0d busy=%b want 0 6 1", OutValid, Sel, Busy); end
    push(7); push(0);
    tick;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (OutValid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL withdraw_bubble cycle=%0d valid=%b want 1", c, OutValid); end
      else begin
        e = sb.pop_front();
        if ({Sel, Out, Grant} !== {e.sel, e.data, 8'(1) << e.sel}) begin failures++; $display("FAIL withdraw_next sel=%0d grant=%h want %0d", Sel, Grant, e.sel); end
      end
      tick;
    end
  endtask

  task automatic test_async_reset;
    reset_dut;
    Req = 8'h10; Last = 8'h10; OutReady = 1;
    tick;
    tick;
    Last = 8'h00;
    tick;
    checks++;
    if (Busy !== 1'b1 || Grant !== 8'h10) begin failures++; $display("FAIL areset_pre busy=%b grant=%h want 1 10", Busy, Grant); end
    rst_n = 0;
    #1;
    checks++;
    if ({Grant, Sel, OutValid, Busy} !== 13'd0) begin failures++; $display("FAIL areset_clear grant=%h sel=%0d valid=%b busy=%b want 0", Grant, Sel, OutValid, Busy); end
    Req = 8'h50;
    #1 rst_n = 1;
    tick;
    checks++;
    if (Grant !== 8'h10 || Sel !== 3'd4) begin failures++; $display("FAIL areset_restart grant=%h sel=%0d want 10 4", Grant, Sel); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) Data[i*32 +: 32] = word(i);
    test_reset;
    test_single;
    test_all_rotate;
    test_hold_single;
    test_max_hold_rotate;
    test_backpressure;
    test_withdraw;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
